// File: rtl/dmem_rmw_ctrl_pkg.sv
// Shared types for the data-memory access sequencer: FSM states and store-width codes.
package dmem_rmw_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_MRG  = 3'd3,
    S_WR   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_NONE = 2'b00;
  localparam sel_t SEL_BYTE = 2'b01;
  localparam sel_t SEL_HALF = 2'b10;
  localparam sel_t SEL_WORD = 2'b11;

endpackage

// File: rtl/dmem_rmw_ctrl_if.sv
// Bus bundle between the MEM stage, the merge selector, the data RAM and the sequencer.
interface dmem_rmw_ctrl_if #(
  parameter int unsigned ADDR_W = 11
);
  import dmem_rmw_ctrl_pkg::*;

  logic              i_req;
  logic              i_we;
  sel_t              i_store_sel;
  logic [31:0]       i_addr;
  logic [31:0]       i_mrg_word;
  sel_t              o_mrg_sel;
  logic [31:0]       o_mrg_addr;
  logic [31:0]       o_mrg_old;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [31:0]       i_mem_rdata;
  logic              o_mem_we;
  logic [31:0]       o_mem_wdata;
  logic [31:0]       o_rdata;
  logic              o_done;
  logic              o_stall;

  modport master (
    output i_req, i_we, i_store_sel, i_addr, i_mrg_word, i_mem_rdata,
    input  o_mrg_sel, o_mrg_addr, o_mrg_old, o_mem_addr, o_mem_we,
           o_mem_wdata, o_rdata, o_done, o_stall
  );

  modport slave (
    input  i_req, i_we, i_store_sel, i_addr, i_mrg_word, i_mem_rdata,
    output o_mrg_sel, o_mrg_addr, o_mrg_old, o_mem_addr, o_mem_we,
           o_mem_wdata, o_rdata, o_done, o_stall
  );

endinterface

// File: rtl/dmem_rmw_ctrl.sv
// Load/store sequencer for a synchronous-read data RAM; sub-word stores run
// read -> merge -> write, stalling the pipeline until done.
module dmem_rmw_ctrl
  import dmem_rmw_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 11
) (
  input logic             i_clk,
  input logic             i_rst,
  dmem_rmw_ctrl_if.slave  bus
);

  state_t            r_state;
  logic              r_we;
  sel_t              r_sel;
  logic [31:0]       r_addr;
  logic [31:0]       r_old;
  logic [31:0]       r_wbuf;
  logic [31:0]       r_rdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_we;
  logic              r_done;
  logic              w_wr_word;

  // mem_we and done are registered on the transition into WR / DONE
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_sel      <= SEL_NONE;
      r_addr     <= '0;
      r_old      <= '0;
      r_wbuf     <= '0;
      r_rdata    <= '0;
      r_mem_addr <= '0;
      r_mem_we   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.i_req) begin
            r_we       <= bus.i_we;
            r_sel      <= bus.i_store_sel;
            r_addr     <= bus.i_addr;
            r_mem_addr <= bus.i_addr[ADDR_W+1:2];
            if (!bus.i_we) begin
              r_state <= S_RD;
            end else if (bus.i_store_sel == SEL_WORD) begin
              r_state  <= S_WR;
              r_mem_we <= 1'b1;
            end else if (bus.i_store_sel == SEL_NONE) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RD;
            end
          end
        end
        S_RD: r_state <= S_CAP;
        S_CAP: begin
          r_old <= bus.i_mem_rdata;
          if (!r_we) begin
            r_rdata <= bus.i_mem_rdata;
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_MRG;
          end
        end
        S_MRG: begin
          r_wbuf   <= bus.i_mrg_word;
          r_state  <= S_WR;
          r_mem_we <= 1'b1;
        end
        S_WR: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Word stores skip the merge cycle, so the selector output goes straight to RAM
  assign w_wr_word       = r_mem_we && (r_sel == SEL_WORD);
  assign bus.o_mem_wdata = w_wr_word ? bus.i_mrg_word : r_wbuf;

  assign bus.o_mem_we   = r_mem_we;
  assign bus.o_mem_addr = r_mem_addr;
  assign bus.o_mrg_sel  = r_sel;
  assign bus.o_mrg_addr = r_addr;
  assign bus.o_mrg_old  = r_old;
  assign bus.o_rdata    = r_rdata;
  assign bus.o_done     = r_done;
  assign bus.o_stall    = bus.i_req & ~r_done;

endmodule
